// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU encodings: funct5, fused sub-ops, rounding modes, fflags bits, FSM states.
package fpu_issue_ctrl_pkg;

    localparam int LAT_W = 8;

    localparam logic [4:0] F5_FADD    = 5'b00000;
    localparam logic [4:0] F5_FSUB    = 5'b00001;
    localparam logic [4:0] F5_FMUL    = 5'b00010;
    localparam logic [4:0] F5_FDIV    = 5'b00011;
    localparam logic [4:0] F5_FSGNJ   = 5'b00100;
    localparam logic [4:0] F5_FMINMAX = 5'b00101;
    localparam logic [4:0] F5_FSQRT   = 5'b01011;

    // Fused sub-op lives in funct5[1:0] when fused=1
    localparam logic [1:0] FUSED_MADD  = 2'b00;
    localparam logic [1:0] FUSED_MSUB  = 2'b01;
    localparam logic [1:0] FUSED_NMSUB = 2'b10;
    localparam logic [1:0] FUSED_NMADD = 2'b11;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational legality, rounding-mode resolution and latency lookup.
// Fused ops are legal only when FPU_FUSED_EN is defined.
module fpu_op_decode
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 12,
    parameter int SQRT_LAT = 12
) (
    input  logic [4:0]       funct5_i,
    input  logic [2:0]       rm_i,
    input  logic [2:0]       fcsr_frm_i,
    input  logic             fused_i,
    output logic             legal_o,
    output logic [2:0]       rm_o,
    output logic [LAT_W-1:0] lat_o
);

    logic rm_ok;

    assign rm_o  = (rm_i == RM_DYN) ? fcsr_frm_i : rm_i;
    assign rm_ok = (rm_o <= RM_RMM);

    always_comb begin
        legal_o = 1'b0;
        lat_o   = '0;
        if (fused_i) begin
`ifdef FPU_FUSED_EN
            legal_o = rm_ok;
            lat_o   = LAT_W'(MUL_LAT + 1);
`endif
        end else begin
            case (funct5_i)
                F5_FADD, F5_FSUB, F5_FSGNJ, F5_FMINMAX: begin
                    legal_o = rm_ok;
                    lat_o   = LAT_W'(1);
                end
                F5_FMUL: begin
                    legal_o = rm_ok;
                    lat_o   = LAT_W'(MUL_LAT);
                end
                F5_FDIV: begin
                    legal_o = rm_ok;
                    lat_o   = LAT_W'(DIV_LAT);
                end
                F5_FSQRT: begin
                    legal_o = rm_ok;
                    lat_o   = LAT_W'(SQRT_LAT);
                end
                default: begin
                    legal_o = 1'b0;
                    lat_o   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issues one FPU op at a time, waits its fixed latency, returns result and flags.
// Fused R4 ops (and fpu_rs3_o/fpu_fused_o) exist only when FPU_FUSED_EN is defined.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 12,
    parameter int SQRT_LAT = 12
) (
    input  logic        clk,
    input  logic        rstLow,
    input  logic        start_i,
    input  logic [4:0]  funct5_i,
    input  logic [2:0]  rm_i,
    input  logic        fused_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rs3_i,
    input  logic [2:0]  fcsr_frm_i,
    output logic [31:0] fpu_rs1_o,
    output logic [31:0] fpu_rs2_o,
    output logic [31:0] fpu_rs3_o,
    output logic [4:0]  fpu_funct5_o,
    output logic [2:0]  fpu_frm_o,
    output logic        fpu_fused_o,
    output logic        fpu_start_o,
    input  logic [31:0] fpu_res_i,
    input  logic [4:0]  fpu_fflags_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] res_o,
    output logic [4:0]  fflags_o,
    output logic        illegal_o,
    output logic [4:0]  fflags_acc_o,
    input  logic        fflags_clr_i
);

    logic [1:0]       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d;
    logic [4:0]       funct5_q, funct5_d;
    logic [2:0]       frm_q, frm_d;
    logic             start_q, start_d;
    logic             illegal_q, illegal_d;
    logic [31:0]      res_q, res_d;
    logic [4:0]       fflags_q, fflags_d;
    logic [4:0]       acc_q, acc_d;
    logic             accept, capture;

    logic             dec_legal;
    logic [2:0]       dec_rm;
    logic [LAT_W-1:0] dec_lat;

    fpu_op_decode #(
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT),
        .SQRT_LAT (SQRT_LAT)
    ) u_dec (
        .funct5_i   (funct5_i),
        .rm_i       (rm_i),
        .fcsr_frm_i (fcsr_frm_i),
        .fused_i    (fused_i),
        .legal_o    (dec_legal),
        .rm_o       (dec_rm),
        .lat_o      (dec_lat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        funct5_d  = funct5_q;
        frm_d     = frm_q;
        start_d   = 1'b0;
        illegal_d = 1'b0;
        res_d     = res_q;
        fflags_d  = fflags_q;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (dec_legal) begin
                        accept   = 1'b1;
                        rs1_d    = rs1_i;
                        rs2_d    = rs2_i;
                        funct5_d = funct5_i;
                        frm_d    = dec_rm;
                        cnt_d    = dec_lat;
                        start_d  = 1'b1;
                        state_d  = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    capture  = 1'b1;
                    res_d    = fpu_res_i;
                    fflags_d = fpu_fflags_i;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A clear coinciding with a capture keeps only the new op's flags
    always_comb begin
        acc_d = acc_q;
        if (capture)
            acc_d = (fflags_clr_i ? 5'b0 : acc_q) | fpu_fflags_i;
        else if (fflags_clr_i)
            acc_d = 5'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstLow) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct5_q  <= '0;
            frm_q     <= '0;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
            res_q     <= '0;
            fflags_q  <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            funct5_q  <= funct5_d;
            frm_q     <= frm_d;
            start_q   <= start_d;
            illegal_q <= illegal_d;
            res_q     <= res_d;
            fflags_q  <= fflags_d;
            acc_q     <= acc_d;
        end
    end

`ifdef FPU_FUSED_EN
    logic [31:0] rs3_q;
    logic        fused_q;

    always_ff @(posedge clk) begin
        if (!rstLow) begin
            rs3_q   <= '0;
            fused_q <= 1'b0;
        end else if (accept) begin
            rs3_q   <= rs3_i;
            fused_q <= fused_i;
        end
    end

    assign fpu_rs3_o   = rs3_q;
    assign fpu_fused_o = fused_q;
`else
    logic unused_rs3;
    logic unused_accept;
    assign unused_rs3    = ^rs3_i;
    assign unused_accept = accept;
    assign fpu_rs3_o     = '0;
    assign fpu_fused_o   = 1'b0;
`endif

    assign fpu_rs1_o    = rs1_q;
    assign fpu_rs2_o    = rs2_q;
    assign fpu_funct5_o = funct5_q;
    assign fpu_frm_o    = frm_q;
    assign fpu_start_o  = start_q;
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign res_o        = res_q;
    assign fflags_o     = fflags_q;
    assign illegal_o    = illegal_q;
    assign fflags_acc_o = acc_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench: stimulus pushes expected done/illegal events, a negedge monitor pops and checks them.
module tb_fpu_issue_ctrl;

    localparam int MUL_LAT  = 2;
    localparam int DIV_LAT  = 12;
    localparam int SQRT_LAT = 12;

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ILL  = 2;

    logic        clk = 1'b0;
    logic        rstLow = 1'b0;
    logic        start_i = 1'b0;
    logic [4:0]  funct5_i = '0;
    logic [2:0]  rm_i = '0;
    logic        fused_i = 1'b0;
    logic [31:0] rs1_i = '0, rs2_i = '0, rs3_i = '0;
    logic [2:0]  fcsr_frm_i = '0;
    logic [31:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o;
    logic [4:0]  fpu_funct5_o;
    logic [2:0]  fpu_frm_o;
    logic        fpu_fused_o, fpu_start_o;
    logic [31:0] fpu_res_i = '0;
    logic [4:0]  fpu_fflags_i = '0;
    logic        busy_o, done_o, illegal_o;
    logic [31:0] res_o;
    logic [4:0]  fflags_o, fflags_acc_o;
    logic        fflags_clr_i = 1'b0;

    typedef struct {
        bit          is_done;
        logic [31:0] res;
        logic [4:0]  fl;
        logic [4:0]  acc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    fpu_issue_ctrl #(
        .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT), .SQRT_LAT (SQRT_LAT)
    ) dut (
        .clk (clk), .rstLow (rstLow), .start_i (start_i), .funct5_i (funct5_i),
        .rm_i (rm_i), .fused_i (fused_i), .rs1_i (rs1_i), .rs2_i (rs2_i),
        .rs3_i (rs3_i), .fcsr_frm_i (fcsr_frm_i), .fpu_rs1_o (fpu_rs1_o),
        .fpu_rs2_o (fpu_rs2_o), .fpu_rs3_o (fpu_rs3_o), .fpu_funct5_o (fpu_funct5_o),
        .fpu_frm_o (fpu_frm_o), .fpu_fused_o (fpu_fused_o), .fpu_start_o (fpu_start_o),
        .fpu_res_i (fpu_res_i), .fpu_fflags_i (fpu_fflags_i), .busy_o (busy_o),
        .done_o (done_o), .res_o (res_o), .fflags_o (fflags_o), .illegal_o (illegal_o),
        .fflags_acc_o (fflags_acc_o), .fflags_clr_i (fflags_clr_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done/illegal pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (done_o || illegal_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: done=%0b illegal=%0b at cycle %0d, none expected",
                         done_o, illegal_o, cyc);
            end else begin
                e = q.pop_front();
                chk("evt_done_kind", 32'(done_o), 32'(e.is_done));
                chk("evt_ill_kind", 32'(illegal_o), 32'(!e.is_done));
                chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                if (e.is_done) begin
                    chk("evt_res", res_o, e.res);
                    chk("evt_fflags", 32'(fflags_o), 32'(e.fl));
                    chk("evt_acc", 32'(fflags_acc_o), 32'(e.acc));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of cycle T+1
    task automatic issue(input logic [4:0] f5, input logic [2:0] rm, input logic [2:0] frm,
                         input logic fu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input int kind, input int lat,
                         input logic [31:0] eres, input logic [4:0] efl, input logic [4:0] eacc);
        exp_t e;
        funct5_i = f5; rm_i = rm; fcsr_frm_i = frm; fused_i = fu;
        rs1_i = a; rs2_i = b; rs3_i = c;
        start_i = 1'b1;
        if (kind != K_NONE) begin
            e.is_done = (kind == K_DONE);
            e.res = eres; e.fl = efl; e.acc = eacc;
            e.cyc = (kind == K_DONE) ? cyc + lat + 1 : cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy_o still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_res"}, res_o, 32'd0);
        chk({tag, "_fflags"}, 32'(fflags_o), 32'd0);
        chk({tag, "_acc"}, 32'(fflags_acc_o), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
        chk({tag, "_start"}, 32'(fpu_start_o), 32'd0);
        chk({tag, "_rs1"}, fpu_rs1_o, 32'd0);
        chk({tag, "_rs2"}, fpu_rs2_o, 32'd0);
        chk({tag, "_funct5"}, 32'(fpu_funct5_o), 32'd0);
        chk({tag, "_frm"}, 32'(fpu_frm_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstLow = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstLow = 1'b1;
        @(negedge clk);

        // FADD 1.0 + 2.0 = 3.0, latency 1
        fpu_res_i = 32'h4040_0000; fpu_fflags_i = 5'b0;
        issue(5'b00000, 3'b000, 3'b000, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h0,
              K_DONE, 1, 32'h4040_0000, 5'b0, 5'b0);
        chk("fadd_start_t1", 32'(fpu_start_o), 32'd1);
        chk("fadd_busy_t1", 32'(busy_o), 32'd1);
        chk("fadd_rs1", fpu_rs1_o, 32'h3F80_0000);
        chk("fadd_rs2", fpu_rs2_o, 32'h4000_0000);
        chk("fadd_frm", 32'(fpu_frm_o), 32'd0);
        @(negedge clk);
        chk("fadd_start_t2", 32'(fpu_start_o), 32'd0);
        chk("fadd_busy_t2", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("fadd_busy_t3", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("fadd_res_hold", res_o, 32'h4040_0000);

        // FDIV with dynamic rounding, starts during busy ignored
        fpu_res_i = 32'h3F00_0000;
        issue(5'b00011, 3'b111, 3'b001, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h0,
              K_DONE, DIV_LAT, 32'h3F00_0000, 5'b0, 5'b0);
        chk("fdiv_frm", 32'(fpu_frm_o), 32'd1);
        chk("fdiv_start", 32'(fpu_start_o), 32'd1);
        chk("fdiv_funct5", 32'(fpu_funct5_o), 32'h03);
        funct5_i = 5'b00000; rm_i = 3'b000; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("fdiv_ignore_start", 32'(fpu_start_o), 32'd0);
        repeat (5) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle();
        chk("fdiv_frm_hold", 32'(fpu_frm_o), 32'd1);
        chk("fdiv_funct5_hold", 32'(fpu_funct5_o), 32'h03);

        // Illegal funct5
        issue(5'b11111, 3'b000, 3'b000, 1'b0, 32'h1, 32'h2, 32'h0, K_ILL, 0, 32'h0, 5'b0, 5'b0);
        chk("ill_f5_busy", 32'(busy_o), 32'd0);
        chk("ill_f5_start", 32'(fpu_start_o), 32'd0);
        @(negedge clk);
        chk("ill_f5_pulse_end", 32'(illegal_o), 32'd0);
        chk("ill_f5_no_latch", 32'(fpu_funct5_o), 32'h03);

        // Illegal dynamic rm 101 and static rm 110
        issue(5'b00000, 3'b111, 3'b101, 1'b0, 32'h1, 32'h2, 32'h0, K_ILL, 0, 32'h0, 5'b0, 5'b0);
        chk("ill_dyn_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        issue(5'b00010, 3'b110, 3'b000, 1'b0, 32'h1, 32'h2, 32'h0, K_ILL, 0, 32'h0, 5'b0, 5'b0);
        chk("ill_rm110_start", 32'(fpu_start_o), 32'd0);
        @(negedge clk);

        // Flag accumulation: NX op, then DZ op with clear in its capture cycle
        fpu_res_i = 32'h0000_0001; fpu_fflags_i = 5'b00001;
        issue(5'b00010, 3'b000, 3'b000, 1'b0, 32'h5, 32'h6, 32'h0,
              K_DONE, MUL_LAT, 32'h0000_0001, 5'b00001, 5'b00001);
        wait_idle();
        chk("acc_after_nx", 32'(fflags_acc_o), 32'h01);
        fpu_res_i = 32'h0000_0002; fpu_fflags_i = 5'b01000;
        issue(5'b00001, 3'b000, 3'b000, 1'b0, 32'h7, 32'h8, 32'h0,
              K_DONE, 1, 32'h0000_0002, 5'b01000, 5'b01000);
        fflags_clr_i = 1'b1;
        @(negedge clk);
        fflags_clr_i = 1'b0;
        wait_idle();
        chk("acc_after_dz_clr", 32'(fflags_acc_o), 32'h08);
        fflags_clr_i = 1'b1;
        @(negedge clk);
        fflags_clr_i = 1'b0;
        chk("acc_idle_clear", 32'(fflags_acc_o), 32'h00);

        // Full FSQRT
        fpu_res_i = 32'h3FB5_04F3; fpu_fflags_i = 5'b00001;
        issue(5'b01011, 3'b000, 3'b000, 1'b0, 32'h4000_0000, 32'h0, 32'h0,
              K_DONE, SQRT_LAT, 32'h3FB5_04F3, 5'b00001, 5'b00001);
        wait_idle();

        // FSQRT aborted by reset in cycle T+5
        fpu_res_i = 32'hDEAD_BEEF; fpu_fflags_i = 5'b10000;
        issue(5'b01011, 3'b010, 3'b000, 1'b0, 32'h4080_0000, 32'h1, 32'h0,
              K_NONE, 0, 32'h0, 5'b0, 5'b0);
        repeat (4) @(negedge clk);
        rstLow = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        rstLow = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset_no_done", 32'(busy_o), 32'd0);
        fpu_res_i = 32'h4040_0000; fpu_fflags_i = 5'b0;
        issue(5'b00000, 3'b000, 3'b000, 1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h0,
              K_DONE, 1, 32'h4040_0000, 5'b0, 5'b0);
        wait_idle();

        // Back-to-back: second start in the IDLE cycle right after DONE
        fpu_res_i = 32'h1111_1111;
        issue(5'b00100, 3'b000, 3'b000, 1'b0, 32'hA, 32'hB, 32'h0,
              K_DONE, 1, 32'h1111_1111, 5'b0, 5'b0);
        @(negedge clk);
        fpu_res_i = 32'h2222_2222;
        @(negedge clk);
        issue(5'b00101, 3'b001, 3'b000, 1'b0, 32'hC, 32'hD, 32'h0,
              K_DONE, 1, 32'h2222_2222, 5'b0, 5'b0);
        chk("b2b_start", 32'(fpu_start_o), 32'd1);
        chk("b2b_rs1", fpu_rs1_o, 32'hC);
        wait_idle();

        // Fused MADD
        fpu_res_i = 32'h3333_3333;
`ifdef FPU_FUSED_EN
        issue(5'b00000, 3'b000, 3'b000, 1'b1, 32'h1, 32'h2, 32'hC000_0000,
              K_DONE, MUL_LAT + 1, 32'h3333_3333, 5'b0, 5'b0);
        chk("fused_flag", 32'(fpu_fused_o), 32'd1);
        chk("fused_rs3", fpu_rs3_o, 32'hC000_0000);
`else
        issue(5'b00000, 3'b000, 3'b000, 1'b1, 32'h1, 32'h2, 32'hC000_0000,
              K_ILL, 0, 32'h0, 5'b0, 5'b0);
        chk("fused_off_flag", 32'(fpu_fused_o), 32'd0);
        chk("fused_off_rs3", fpu_rs3_o, 32'd0);
        chk("fused_off_busy", 32'(busy_o), 32'd0);
`endif
        wait_idle();

        repeat (3) @(negedge clk);
        chk("pending_expectations", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter: MUL_LAT, 2, FMUL cycles from fpu_start_o to result sample (>=1).
REQ-002 Parameter: DIV_LAT, 12, FDIV cycles from fpu_start_o to result sample (>=1).
REQ-003 Parameter: SQRT_LAT, 12, FSQRT cycles from fpu_start_o to result sample (>=1).
REQ-004 Port: clk in 1, the single clock; all state SHALL update on its rising edge.
REQ-005 Port: rstLow in 1, synchronous active-low reset.
REQ-006 Ports: start_i in 1 (op request); funct5_i in 5; rm_i in 3 (instruction rm field); fused_i in 1 (R4-type op, funct5_i[1:0] = MADD/MSUB/NMSUB/NMADD).
REQ-007 Ports: rs1_i, rs2_i, rs3_i in 32 each (operands); fcsr_frm_i in 3 (dynamic rounding mode).
REQ-008 Ports: fpu_rs1_o, fpu_rs2_o, fpu_rs3_o out 32 each; fpu_funct5_o out 5; fpu_frm_o out 3; fpu_fused_o out 1; fpu_start_o out 1.
REQ-009 Ports: fpu_res_i in 32; fpu_fflags_i in 5 ({NV,DZ,OF,UF,NX}).
REQ-010 Ports: busy_o out 1; done_o out 1; res_o out 32; fflags_o out 5 (per-op flags); illegal_o out 1; fflags_acc_o out 5 (sticky); fflags_clr_i in 1.

Function
REQ-011 FSM states SHALL be IDLE, EXEC, DONE.
REQ-012 Supported funct5: FADD 00000, FSUB 00001, FMUL 00010, FDIV 00011, FSGNJ 00100, FMINMAX 00101, FSQRT 01011; any other value with fused_i=0 SHALL be illegal.
REQ-013 Resolved rm = fcsr_frm_i when rm_i=111, else rm_i; resolved rm of 101, 110 or 111 SHALL be illegal.
REQ-014 In IDLE with start_i=1 and illegal: illegal_o SHALL pulse for exactly 1 cycle (next cycle), FSM stays IDLE, no fpu_start_o.
REQ-015 In IDLE with start_i=1 and legal (accept cycle T): latch operands, funct5, resolved rm, fused_i into fpu_*_o, load latency counter, move to EXEC.
REQ-016 Latency L: ADD/SUB/SGNJ/MINMAX = 1; FMUL = MUL_LAT; FDIV = DIV_LAT; FSQRT = SQRT_LAT; fused = MUL_LAT+1.
REQ-017 fpu_start_o SHALL be 1 only in cycle T+1 (first EXEC cycle).
REQ-018 Counter decrements once per EXEC cycle; in cycle T+L fpu_res_i and fpu_fflags_i are captured into res_o/fflags_o, FSM moves to DONE.
REQ-019 DONE lasts exactly 1 cycle (T+L+1): done_o=1, res_o/fflags_o valid; FSM returns to IDLE.
REQ-020 res_o/fflags_o SHALL hold their values until the next capture.
REQ-021 busy_o SHALL be 1 in EXEC and DONE, 0 in IDLE; start_i SHALL be ignored while busy_o=1 (no queuing).
REQ-022 A new start_i in the cycle immediately after DONE (IDLE) SHALL be accepted; back-to-back throughput = L+2 cycles.
REQ-023 fflags_acc_o SHALL OR in fflags_o in the capture cycle; fflags_clr_i=1 clears it; simultaneous clear and capture SHALL leave exactly the new op's flags.
REQ-024 fpu_*_o operand/control outputs SHALL hold latched values from accept until the next accept.

Reset
REQ-025 rstLow=0 at a clock edge SHALL force IDLE, counter 0, and all outputs (including fflags_acc_o, res_o, fpu_*_o) to 0.
REQ-026 Reset mid-EXEC SHALL abort the op: no done_o, no flag accumulation; the FPU result in flight is discarded.

Configuration
REQ-027 Macro FPU_FUSED_EN defined: fused_i=1 ops are legal with latency MUL_LAT+1, fpu_fused_o and fpu_rs3_o driven from latched values.
REQ-028 FPU_FUSED_EN undefined: any start_i with fused_i=1 SHALL be illegal; fpu_fused_o and fpu_rs3_o SHALL be tied to 0.

Structure
REQ-029 funct5 encodings, fused sub-op codes, rm codes (RNE 000 ... DYN 111), fflags bit positions and FSM state encodings SHALL reside in the shared FPU defines/package.
REQ-030 Legality and latency lookup SHALL be one combinational sub-module fpu_op_decode (inputs funct5, rm, fcsr_frm, fused; outputs legal, resolved rm, latency); FSM and registers stay in fpu_issue_ctrl.

Verification
REQ-031 FADD 0x3F800000+0x40000000, rm=000, start at T -> fpu_start_o at T+1, done_o at T+2, res_o=0x40400000, busy_o high T+1..T+2.
REQ-032 FDIV with DIV_LAT=12, rm_i=111, fcsr_frm_i=001 -> fpu_frm_o=001, done_o exactly at T+13, start_i pulses during busy ignored.
REQ-033 funct5=11111, or rm_i=111 with fcsr_frm_i=101 -> illegal_o 1-cycle pulse, no fpu_start_o, busy_o stays 0.
REQ-034 Op returning NX, then op returning DZ with fflags_clr_i asserted in its capture cycle -> fflags_acc_o=00001, then 01000.
REQ-035 rstLow=0 at T+5 of an FSQRT -> next cycle all outputs 0, no done_o; following FADD completes normally.
REQ-036 fused_i=1 funct5=00000 -> with FPU_FUSED_EN done_o at T+MUL_LAT+2; without it illegal_o pulses.
